directory_controller: RTL and testbench

Home-node directory and memory controller that sits directly downstream of the per-processor L1 caches in the directory-based coherence system.
- Consumes each cache's miss/invalidate message and request address.
- Keeps a per-block directory entry: state plus sharer vector.
- Issues invalidate/fetch probes back to the caches and collects owner write-backs.
- Returns the requested block from an internal memory array.

---
 rtl/dir_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/directory_controller.sv | 176 +++++++++++++++++
 tb/tb_directory_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// dir_pkg: shared directory-state, message-bit and FSM encodings for the
// directory controller.
package dir_pkg;
    localparam logic [1:0] UNCACHED  = 2'd0;
    localparam logic [1:0] SHARED    = 2'd1;
    localparam logic [1:0] EXCLUSIVE = 2'd2;

    localparam int READ_MISS  = 2;
    localparam int WRITE_MISS = 1;
    localparam int INVALIDATE = 0;

    localparam logic [2:0] MSG_RD  = 3'b100;
    localparam logic [2:0] MSG_WR  = 3'b010;
    localparam logic [2:0] MSG_INV = 3'b001;

    typedef enum logic [2:0] {IDLE, PROBE, WB_WAIT, MEM, REPLY} fsm_e;

    // Encoding 3 never gets written but is folded into UNCACHED if seen.
    function automatic logic [1:0] norm_state(input logic [1:0] s);
        return (s == 2'd3) ? UNCACHED : s;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer moves past the
// granted requester whenever a grant is issued.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && en_i && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/directory_controller.sv
// directory_controller: home-node directory plus backing memory; serialises
// cache misses, probes sharers/owners, collects write-backs, replies with data.
module directory_controller
    import dir_pkg::*;
#(
    parameter int NUM_CACHES  = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CACHES-1:0]        req_valid,
    input  logic [3*NUM_CACHES-1:0]      req_msg,
    input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
    output logic [NUM_CACHES-1:0]        req_ready,
    input  logic [NUM_CACHES-1:0]        wb_valid,
    input  logic [DATA_W*NUM_CACHES-1:0] wb_data,
    output logic [2:0]                   bus_msg,
    output logic [NUM_CACHES-1:0]        bus_target,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [NUM_CACHES-1:0]        reply_valid,
    output logic [DATA_W-1:0]            reply_data
);
    localparam int DEPTH = 1 << ADDR_W;

    fsm_e                  state_q, state_d;
    logic [NUM_CACHES-1:0] req_q, req_d, tgt_q, tgt_d, nsh_q, nsh_d, grant, cur_sh;
    logic [ADDR_W-1:0]     addr_q, addr_d, sel_addr;
    logic [2:0]            pmsg_q, pmsg_d, sel_msg;
    logic [1:0]            nst_q, nst_d, cur_st;
    logic                  wb_q, wb_d, wb_hit, wb_take;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     sel_wb;

    logic [1:0]            dir_st_q [DEPTH];
    logic [NUM_CACHES-1:0] dir_sh_q [DEPTH];
    logic [DATA_W-1:0]     mem_q    [DEPTH];

    rr_arbiter #(.N(NUM_CACHES)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req_valid),
        .en_i   (state_q == IDLE),
        .grant_o(grant)
    );

    always_comb begin
        sel_addr = '0;
        sel_msg  = '0;
        sel_wb   = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (grant[i]) begin
                sel_addr |= req_addr[i*ADDR_W +: ADDR_W];
                sel_msg  |= req_msg[3*i +: 3];
            end
            if (tgt_q[i] && wb_valid[i]) sel_wb |= wb_data[i*DATA_W +: DATA_W];
        end
    end

    assign cur_st  = norm_state(dir_st_q[sel_addr]);
    assign cur_sh  = dir_sh_q[sel_addr];
    assign wb_hit  = |(wb_valid & tgt_q);
    assign wb_take = wb_hit && ((state_q == PROBE && wb_q) || state_q == WB_WAIT);

    // The whole transaction plan (probe, next directory entry) is fixed at accept.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        pmsg_d      = pmsg_q;
        tgt_d       = tgt_q;
        wb_d        = wb_q;
        nst_d       = nst_q;
        nsh_d       = nsh_q;
        cnt_d       = cnt_q;
        req_ready   = '0;
        bus_msg     = '0;
        bus_target  = '0;
        bus_addr    = '0;
        reply_valid = '0;
        reply_data  = '0;
        case (state_q)
            IDLE: if (|grant) begin
                req_ready = grant;
                if ($onehot(sel_msg)) begin
                    req_d   = grant;
                    addr_d  = sel_addr;
                    pmsg_d  = '0;
                    tgt_d   = '0;
                    wb_d    = 1'b0;
                    cnt_d   = 4'(MEM_LATENCY);
                    state_d = MEM;
                    if (sel_msg[READ_MISS]) begin
                        nst_d = SHARED;
                        nsh_d = (cur_st == UNCACHED) ? grant : (cur_sh | grant);
                        if (cur_st == EXCLUSIVE) begin
                            pmsg_d  = MSG_RD;
                            tgt_d   = cur_sh;
                            wb_d    = 1'b1;
                            state_d = PROBE;
                        end
                    end else begin
                        nst_d = EXCLUSIVE;
                        nsh_d = grant;
                        if (cur_st == SHARED && |(cur_sh & ~grant)) begin
                            pmsg_d  = MSG_INV;
                            tgt_d   = cur_sh & ~grant;
                            state_d = PROBE;
                        end else if (cur_st == EXCLUSIVE && cur_sh != grant) begin
                            pmsg_d  = MSG_WR;
                            tgt_d   = cur_sh;
                            wb_d    = 1'b1;
                            state_d = PROBE;
                        end
                    end
                end
            end
            PROBE: begin
                bus_msg    = pmsg_q;
                bus_target = tgt_q;
                bus_addr   = addr_q;
                state_d    = (wb_q && !wb_hit) ? WB_WAIT : MEM;
            end
            WB_WAIT: state_d = wb_hit ? MEM : WB_WAIT;
            MEM: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q <= 4'd1) ? REPLY : MEM;
            end
            REPLY: begin
                reply_valid = req_q;
                reply_data  = mem_q[addr_q];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            pmsg_q  <= '0;
            tgt_q   <= '0;
            wb_q    <= 1'b0;
            nst_q   <= UNCACHED;
            nsh_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pmsg_q  <= pmsg_d;
            tgt_q   <= tgt_d;
            wb_q    <= wb_d;
            nst_q   <= nst_d;
            nsh_q   <= nsh_d;
            cnt_q   <= cnt_d;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dir_st_q[i] <= UNCACHED;
                dir_sh_q[i] <= '0;
                mem_q[i]    <= '0;
            end
        end else begin
            if (wb_take) mem_q[addr_q] <= sel_wb;
            if (state_q == REPLY) begin
                dir_st_q[addr_q] <= nst_q;
                dir_sh_q[addr_q] <= nsh_q;
            end
        end
endmodule

// File: tb/tb_directory_controller.sv
// tb_directory_controller: directed coherence scenarios; replies are checked
// against a scoreboard queue filled when each request is driven.
module tb_directory_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, wb_valid, bus_target, reply_valid;
    logic [5:0]  req_msg;
    logic [15:0] req_addr, wb_data;
    logic [2:0]  bus_msg;
    logic [7:0]  bus_addr, reply_data;

    int          errors = 0;
    int          checks = 0;
    logic [9:0]  sb[$];

    directory_controller #(.NUM_CACHES(2), .ADDR_W(8), .DATA_W(8), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_msg(req_msg),
        .req_addr(req_addr), .req_ready(req_ready), .wb_valid(wb_valid),
        .wb_data(wb_data), .bus_msg(bus_msg), .bus_target(bus_target),
        .bus_addr(bus_addr), .reply_valid(reply_valid), .reply_data(reply_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every reply must match the oldest outstanding expectation.
    always @(negedge clk)
        if (rst_n && reply_valid != 2'b00) begin
            if (sb.size() == 0) chk("unexpected_reply", 32'(reply_valid), 32'h0);
            else begin
                logic [9:0] e;
                e = sb.pop_front();
                chk("reply_target", 32'(reply_valid), 32'(e[9:8]));
                chk("reply_data", 32'(reply_data), 32'(e[7:0]));
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_reply_valid"}, 32'(reply_valid), 32'h0);
        chk({tag, "_reply_data"}, 32'(reply_data), 32'h0);
        chk({tag, "_bus_msg"}, 32'(bus_msg), 32'h0);
        chk({tag, "_bus_target"}, 32'(bus_target), 32'h0);
        chk({tag, "_bus_addr"}, 32'(bus_addr), 32'h0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        wb_valid = '0;
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic request(input logic [1:0] who, input logic [1:0] winner, input logic [2:0] msg,
                           input logic [7:0] a, input logic [7:0] data, input bit expect_reply);
        tick();
        req_valid = who;
        req_msg   = {msg, msg};
        req_addr  = {a, a};
        if (expect_reply) sb.push_back({winner, data});
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(winner));
    endtask

    task automatic await_reply(input string tag, input int exp_lat, input int wb_n, input logic [1:0] wb_who,
                               input logic [7:0] wbd, input logic [2:0] exp_pmsg, input logic [1:0] exp_tgt);
        int         lat = 0;
        int         np  = 0;
        int         pn  = 0;
        logic [2:0] pm  = '0;
        logic [1:0] pt  = '0;
        logic [7:0] pa  = '0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            req_valid = '0;
            wb_valid  = (n == wb_n) ? wb_who : 2'b00;
            wb_data   = {wbd, wbd};
            @(negedge clk);
            if (bus_msg != 3'b000) begin
                np++;
                pn = n;
                pm = bus_msg;
                pt = bus_target;
                pa = bus_addr;
            end
            if (reply_valid != 2'b00) lat = n;
        end
        wb_valid = '0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_probe_cycles"}, 32'(np), (exp_pmsg != 3'b000) ? 32'h1 : 32'h0);
        chk({tag, "_probe_slot"}, 32'(pn), (exp_pmsg != 3'b000) ? 32'h1 : 32'h0);
        chk({tag, "_probe_msg"}, 32'(pm), 32'(exp_pmsg));
        chk({tag, "_probe_target"}, 32'(pt), 32'(exp_tgt));
        chk({tag, "_probe_addr"}, 32'(pa), (exp_pmsg != 3'b000) ? 32'h10 : 32'h0);
    endtask

    task automatic chk_dir(input string tag, input logic [1:0] st, input logic [1:0] sh);
        tick();
        chk({tag, "_dir_state"}, 32'(dut.dir_st_q[8'h10]), 32'(st));
        chk({tag, "_dir_sharers"}, 32'(dut.dir_sh_q[8'h10]), 32'(sh));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_msg   = '0;
        req_addr  = '0;
        wb_valid  = '0;
        wb_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        tick();
        rst_n = 1'b1;

        // Uncached read: reply at T+1+MEM_LATENCY with zero data.
        request(2'b01, 2'b01, 3'b100, 8'h10, 8'h00, 1);
        await_reply("rd_uncached", 3, 0, 2'b00, 8'h00, 3'b000, 2'b00);
        chk_dir("rd_uncached", 2'd1, 2'b01);

        // Fresh pointer so cache0 wins the simultaneous pair.
        do_reset();
        request(2'b11, 2'b01, 3'b100, 8'h10, 8'h00, 1);
        await_reply("rd_pair0", 3, 0, 2'b00, 8'h00, 3'b000, 2'b00);
        request(2'b10, 2'b10, 3'b100, 8'h10, 8'h00, 1);
        await_reply("rd_pair1", 3, 0, 2'b00, 8'h00, 3'b000, 2'b00);
        chk_dir("rd_pair", 2'd1, 2'b11);

        request(2'b10, 2'b10, 3'b001, 8'h10, 8'h00, 1);
        await_reply("upgrade", 4, 0, 2'b00, 8'h00, 3'b001, 2'b01);
        chk_dir("upgrade", 2'd2, 2'b10);

        request(2'b01, 2'b01, 3'b100, 8'h10, 8'hA5, 1);
        await_reply("rd_owned", 7, 4, 2'b10, 8'hA5, 3'b100, 2'b10);
        chk_dir("rd_owned", 2'd1, 2'b11);
        chk("rd_owned_mem", 32'(dut.mem_q[8'h10]), 32'hA5);

        request(2'b10, 2'b10, 3'b010, 8'h10, 8'hA5, 1);
        await_reply("wr_shared", 4, 0, 2'b00, 8'h00, 3'b001, 2'b01);
        chk_dir("wr_shared", 2'd2, 2'b10);

        request(2'b01, 2'b01, 3'b010, 8'h10, 8'h3C, 1);
        await_reply("wr_owned", 4, 1, 2'b10, 8'h3C, 3'b010, 2'b10);
        chk_dir("wr_owned", 2'd2, 2'b01);
        chk("wr_owned_mem", 32'(dut.mem_q[8'h10]), 32'h3C);

        // Malformed message: accepted with no reply, next request taken at once.
        request(2'b01, 2'b01, 3'b011, 8'h10, 8'h00, 0);
        request(2'b10, 2'b10, 3'b100, 8'h20, 8'h00, 1);
        await_reply("after_illegal", 3, 0, 2'b00, 8'h00, 3'b000, 2'b00);
        chk_dir("after_illegal", 2'd2, 2'b01);

        // Reset in WB_WAIT aborts the transaction and wipes the directory.
        request(2'b10, 2'b10, 3'b010, 8'h10, 8'h00, 0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("abort_probe_msg", 32'(bus_msg), 32'(3'b010));
        chk("abort_probe_target", 32'(bus_target), 32'(2'b01));
        tick();
        @(negedge clk);
        chk("abort_waiting", 32'(bus_msg | {1'b0, reply_valid}), 32'h0);
        tick();
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_outputs_zero("abort");
        chk("abort_dir", 32'(dut.dir_st_q[8'h10]), 32'h0);
        tick();
        rst_n = 1'b1;
        request(2'b01, 2'b01, 3'b100, 8'h10, 8'h00, 1);
        await_reply("post_reset", 3, 0, 2'b00, 8'h00, 3'b000, 2'b00);
        chk_dir("post_reset", 2'd1, 2'b01);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
